// File: rtl/retire_recovery_ctrl_if.sv
// Retire/recovery bundle: ROB head slots in, commit/RAT/front-end controls out.
interface retire_recovery_ctrl_if #(
  parameter int CNT_W = 8
);
  logic [2:0]      ready_ret;
  logic [2:0]      excep_ret;
  logic [2:0][1:0] Type_ret;
  logic [2:0][4:0] Pw_ret;
  logic [2:0][4:0] Pw_old_ret;
  logic [2:0][2:0] Rw_ret;
  logic            ext_flush_req;
  logic [2:0]      commit;
  logic [2:0][2:0] arch_Rw;
  logic [2:0][4:0] arch_Pw;
  logic [2:0][4:0] free_Pw;
  logic            flush;
  logic            freeze_front;
  logic            rat_restore;
  logic            redirect;
  logic [CNT_W-1:0] excep_cnt;

  modport master (
    output ready_ret, excep_ret, Type_ret,
    output Pw_ret, Pw_old_ret, Rw_ret,
    output ext_flush_req,
    input  commit, arch_Rw, arch_Pw, free_Pw,
    input  flush, freeze_front, rat_restore,
    input  redirect, excep_cnt
  );

  modport slave (
    input  ready_ret, excep_ret, Type_ret,
    input  Pw_ret, Pw_old_ret, Rw_ret,
    input  ext_flush_req,
    output commit, arch_Rw, arch_Pw, free_Pw,
    output flush, freeze_front, rat_restore,
    output redirect, excep_cnt
  );
endinterface

// File: rtl/retire_recovery_ctrl.sv
// In-order 3-wide retirement qualifier plus
// FLUSH -> RESTORE -> RESUME exception recovery sequencer.
module retire_recovery_ctrl #(
  parameter int RESTORE_CYCLES = 8,
  parameter int CNT_W          = 8
) (
  input logic                 clk,
  input logic                 rst,
  retire_recovery_ctrl_if.slave bus
);
  localparam int RC_W = $clog2(RESTORE_CYCLES + 1);
  localparam logic [RC_W-1:0] RC_LOAD =
    RC_W'(RESTORE_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN, FLUSH, RESTORE, RESUME
  } state_t;

  state_t           state, state_nxt;
  logic [RC_W-1:0]  rcnt, rcnt_nxt;
  logic [CNT_W-1:0] ecnt, ecnt_nxt;
  logic             run;
  logic             exc;
  logic [2:0]       ok;
  logic [2:0]       hit;
  logic [2:0]       cmt;
  logic             unused_type;

  // store-type gating is done by the RAT/free-list consumers
  assign unused_type = ^bus.Type_ret;

  assign run = (state == RUN) & rst;
  assign ok  = bus.ready_ret & ~bus.excep_ret;
  assign hit = bus.ready_ret & bus.excep_ret;

  assign cmt[0] = run & ok[0];
  assign cmt[1] = cmt[0] & ok[1];
  assign cmt[2] = cmt[1] & ok[2];

  // exception only counts at the first non-committing slot
  assign exc = run & (hit[0] |
                      (cmt[0] & hit[1]) |
                      (cmt[1] & hit[2]));

  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    ecnt_nxt  = ecnt;
    unique case (state)
      RUN: begin
        if (exc | (run & bus.ext_flush_req))
          state_nxt = FLUSH;
        if (exc && (ecnt != '1))
          ecnt_nxt = ecnt + CNT_W'(1);
      end
      FLUSH: begin
        rcnt_nxt  = RC_LOAD;
        state_nxt = RESTORE;
      end
      RESTORE: begin
        if (rcnt == '0)
          state_nxt = RESUME;
        else
          rcnt_nxt = rcnt - RC_W'(1);
      end
      RESUME: state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      rcnt  <= '0;
      ecnt  <= '0;
    end else begin
      state <= state_nxt;
      rcnt  <= rcnt_nxt;
      ecnt  <= ecnt_nxt;
    end
  end

  assign bus.commit  = cmt;
  assign bus.arch_Rw = rst ? bus.Rw_ret : '0;
  assign bus.arch_Pw = rst ? bus.Pw_ret : '0;
  assign bus.free_Pw = rst ? bus.Pw_old_ret : '0;

  assign bus.flush        = (state == FLUSH);
  assign bus.freeze_front = (state == FLUSH) |
                            (state == RESTORE);
  assign bus.rat_restore  = (state == RESTORE);
  assign bus.redirect     = (state == RESUME);
  assign bus.excep_cnt    = ecnt;
endmodule
